// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: pops bytes from the UART RX FIFO, filters them against
// the command set, strobes valid commands to the ASCII decoder, echoes handled
// bytes into the UART TX FIFO and enforces a minimum inter-command gap.
//
// Ports:
//   iClk        system clock
//   iRst        synchronous active-high reset
//   iEnable     1 = allowed to start popping new bytes
//   iRx_Empty   RX FIFO empty flag (sampled only in IDLE)
//   oRx_Rd      RX FIFO pop strobe; data valid on iRx_Data the next cycle
//   iRx_Data    RX FIFO read data
//   iTx_Full    TX FIFO full flag
//   oTx_Wr      TX FIFO push strobe
//   oTx_Data    TX FIFO write data (echo byte while in ECHO, else 0)
//   oAscii      command byte to decoder, 0 outside PRESENT
//   oCmd_Valid  high for exactly the PRESENT cycle
//   oBusy       high in every state except IDLE
//   oCmd_Cnt    commands presented, modulo 256
module uart_cmd_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter bit ECHO_EN    = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEnable,
    input  logic       iRx_Empty,
    output logic       oRx_Rd,
    input  logic [7:0] iRx_Data,
    input  logic       iTx_Full,
    output logic       oTx_Wr,
    output logic [7:0] oTx_Data,
    output logic [7:0] oAscii,
    output logic       oCmd_Valid,
    output logic       oBusy,
    output logic [7:0] oCmd_Cnt
);

    // Gap counter runs 0 .. GAP_CYCLES-1 while in GAP.
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LAST =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [7:0] REJECT_ECHO = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_PRESENT,
        S_ECHO,
        S_GAP
    } state_t;

    state_t        state;
    state_t        state_nx;
    state_t        after_echo;
    state_t        after_present;

    logic [7:0]    byte_q;
    logic [7:0]    echo_q;
    logic [7:0]    cmd_cnt;
    logic [CW-1:0] gap_cnt;

    logic          rx_valid;
    logic          rx_drop;

    // Classify the byte the FIFO is presenting during LATCH.
    always_comb begin
        rx_valid = 1'b0;
        rx_drop  = 1'b0;
        case (iRx_Data)
            8'h43, 8'h57, 8'h54, 8'h55,
            8'h44, 8'h75, 8'h64, 8'h6C,
            8'h72, 8'h4D, 8'h53, 8'h58: rx_valid = 1'b1;
            8'h0D, 8'h0A:               rx_drop  = 1'b1;
            default: ;
        endcase
    end

    // Disabled stages collapse onto the next one in the chain.
    always_comb begin
        after_echo    = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        after_present = ECHO_EN ? S_ECHO : after_echo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (iEnable && !iRx_Empty) begin
                    state_nx = S_POP;
                end
            end
            S_POP: begin
                state_nx = S_LATCH;
            end
            S_LATCH: begin
                if (rx_valid) begin
                    state_nx = S_PRESENT;
                end else if (rx_drop) begin
                    state_nx = after_echo;
                end else begin
                    state_nx = after_present;
                end
            end
            S_PRESENT: begin
                state_nx = after_present;
            end
            S_ECHO: begin
                if (!iTx_Full) begin
                    state_nx = after_echo;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= S_IDLE;
            byte_q  <= '0;
            echo_q  <= '0;
            gap_cnt <= '0;
            cmd_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_LATCH) begin
                byte_q <= iRx_Data;
                echo_q <= rx_valid ? iRx_Data : REJECT_ECHO;
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + CW'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (state == S_PRESENT) begin
                cmd_cnt <= cmd_cnt + 8'd1;
            end
        end
    end

    // The TX push is qualified by iTx_Full in the same cycle so the echo
    // lands on the first non-full cycle without an extra wait state.
    always_comb begin
        oRx_Rd     = (state == S_POP);
        oCmd_Valid = (state == S_PRESENT);
        oAscii     = (state == S_PRESENT) ? byte_q : 8'h00;
        oTx_Wr     = ECHO_EN && (state == S_ECHO) && !iTx_Full;
        oTx_Data   = (state == S_ECHO) ? echo_q : 8'h00;
        oBusy      = (state != S_IDLE);
        oCmd_Cnt   = cmd_cnt;
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: FIFO model, event monitor and a byte-level
// reference model of which bytes get presented, echoed and counted.
module tb_uart_cmd_sequencer;

    localparam int GAP = 4;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEnable;
    logic       iRx_Empty = 1'b1;
    logic       oRx_Rd;
    logic [7:0] iRx_Data = 8'h00;
    logic       iTx_Full;
    logic       oTx_Wr;
    logic [7:0] oTx_Data;
    logic [7:0] oAscii;
    logic       oCmd_Valid;
    logic       oBusy;
    logic [7:0] oCmd_Cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    logic [7:0] pres_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_pres[$];
    logic [7:0] exp_echo[$];
    int         pop_cyc[$];
    int         pres_cyc[$];
    int         exp_cnt;
    int         pushed;

    logic [7:0] vset[12] = '{8'h43, 8'h57, 8'h54, 8'h55, 8'h44, 8'h75,
                             8'h64, 8'h6C, 8'h72, 8'h4D, 8'h53, 8'h58};

    uart_cmd_sequencer #(
        .GAP_CYCLES(GAP),
        .ECHO_EN   (1'b1)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iEnable   (iEnable),
        .iRx_Empty (iRx_Empty),
        .oRx_Rd    (oRx_Rd),
        .iRx_Data  (iRx_Data),
        .iTx_Full  (iTx_Full),
        .oTx_Wr    (oTx_Wr),
        .oTx_Data  (oTx_Data),
        .oAscii    (oAscii),
        .oCmd_Valid(oCmd_Valid),
        .oBusy     (oBusy),
        .oCmd_Cnt  (oCmd_Cnt)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RX FIFO: pop seen at the edge, data valid the following cycle.
    always @(posedge iClk) begin
        if (oRx_Rd === 1'b1) begin
            chk("pop_nonempty", 32'(rx_q.size() != 0), 32'd1);
            if (rx_q.size() != 0) iRx_Data <= rx_q.pop_front();
        end
        #1 iRx_Empty = (rx_q.size() == 0);
    end

    // Event monitor, sampled mid low phase after inputs settle.
    always @(negedge iClk) begin
        #2;
        if (oRx_Rd === 1'b1) pop_cyc.push_back(cyc);
        if (oCmd_Valid === 1'b1) begin
            pres_q.push_back(oAscii);
            pres_cyc.push_back(cyc);
        end else if (oCmd_Valid === 1'b0) begin
            chk("ascii_idle", 32'(oAscii), 32'd0);
        end
        if (oTx_Wr === 1'b1) begin
            tx_q.push_back(oTx_Data);
            chk("wr_when_full", 32'(iTx_Full), 32'd0);
        end
    end

    function automatic bit is_cmd(input logic [7:0] b);
        return b inside {"C", "W", "T", "U", "D", "u",
                         "d", "l", "r", "M", "S", "X"};
    endfunction

    task automatic clear();
        pres_q.delete();
        tx_q.delete();
        exp_pres.delete();
        exp_echo.delete();
        pop_cyc.delete();
        pres_cyc.delete();
        exp_cnt = 0;
        pushed  = 0;
    endtask

    task automatic push_raw(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        pushed++;
        if (is_cmd(b)) begin
            exp_pres.push_back(b);
            exp_echo.push_back(b);
            exp_cnt++;
        end else if (b != 8'h0D && b != 8'h0A) begin
            exp_echo.push_back(8'h3F);
        end
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iEnable  = 1'b0;
        iTx_Full = 1'b0;
        iRst     = 1'b1;
        rx_q.delete();
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        clear();
        iEnable = 1'b1;
    endtask

    task automatic drain(input int budget, input bit rand_full);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || oBusy) && n < budget) begin
            @(negedge iClk);
            if (rand_full) iTx_Full = ($urandom_range(0, 2) == 0);
            n++;
        end
        iTx_Full = 1'b0;
        repeat (2) @(negedge iClk);
        chk("drain_bound", 32'(n < budget), 32'd1);
    endtask

    task automatic compare_model(input string t);
        chk({t, "_pops"}, pop_cyc.size(), pushed);
        chk({t, "_npres"}, pres_q.size(), exp_pres.size());
        foreach (exp_pres[i]) chk({t, "_pres"}, 32'(pres_q[i]), 32'(exp_pres[i]));
        chk({t, "_necho"}, tx_q.size(), exp_echo.size());
        foreach (exp_echo[i]) chk({t, "_echo"}, 32'(tx_q[i]), 32'(exp_echo[i]));
        chk({t, "_cnt"}, 32'(oCmd_Cnt), 32'(exp_cnt % 256));
        chk({t, "_busy"}, 32'(oBusy), 32'd0);
    endtask

    task automatic wait_rd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge iClk);
            if (oRx_Rd) seen = 1'b1;
        end
    endtask

    task automatic wait_pres(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge iClk);
            if (pres_q.size() == n) seen = 1'b1;
        end
    endtask

    task automatic chk_quiet(input string t);
        chk({t, "_busy"}, 32'(oBusy), 32'd0);
        chk({t, "_rd"}, 32'(oRx_Rd), 32'd0);
        chk({t, "_valid"}, 32'(oCmd_Valid), 32'd0);
        chk({t, "_ascii"}, 32'(oAscii), 32'd0);
        chk({t, "_wr"}, 32'(oTx_Wr), 32'd0);
        chk({t, "_txd"}, 32'(oTx_Data), 32'd0);
        chk({t, "_cnt"}, 32'(oCmd_Cnt), 32'd0);
    endtask

    initial begin
        bit         seen;
        int         mg;
        int         r;
        logic [7:0] b;

        iRst     = 1'b1;
        iEnable  = 1'b0;
        iTx_Full = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        clear();
        chk_quiet("reset");

        // 1: single valid byte, latency and echo
        do_reset();
        push("U");
        drain(100, 1'b0);
        compare_model("t1");
        chk("t1_lat", pres_cyc[0] - pop_cyc[0], 32'd2);

        // 2: invalid, drop, valid
        do_reset();
        push("A");
        push(8'h0D);
        push("S");
        drain(200, 1'b0);
        compare_model("t2");

        // 3: TX full stall during echo of "u"
        do_reset();
        iTx_Full = 1'b1;
        push("u");
        push("C");
        wait_pres(1, seen);
        chk("t3_present", 32'(seen), 32'd1);
        repeat (20) @(negedge iClk);
        chk("t3_busy", 32'(oBusy), 32'd1);
        chk("t3_no_wr", tx_q.size(), 32'd0);
        chk("t3_no_pop", pop_cyc.size(), 32'd1);
        iTx_Full = 1'b0;
        @(negedge iClk);
        chk("t3_first_wr", tx_q.size(), 32'd1);
        chk("t3_first_data", 32'(tx_q[0]), 32'h75);
        drain(200, 1'b0);
        compare_model("t3");

        // 4: 300 random valid bytes streamed
        do_reset();
        for (int i = 0; i < 300; i++) push(vset[$urandom_range(0, 11)]);
        drain(4000, 1'b0);
        compare_model("t4");
        chk("t4_cnt_wrap", 32'(oCmd_Cnt), 32'h2C);
        mg = 1000;
        for (int i = 1; i < pres_cyc.size(); i++)
            if (pres_cyc[i] - pres_cyc[i - 1] < mg)
                mg = pres_cyc[i] - pres_cyc[i - 1];
        chk("t4_min_gap", 32'(mg >= 5 + GAP), 32'd1);

        // random mix with random TX back-pressure
        do_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 3);
            if (r < 2) b = vset[$urandom_range(0, 11)];
            else if (r == 2) b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            else b = 8'($urandom_range(0, 255));
            push(b);
        end
        drain(3000, 1'b1);
        compare_model("mix");

        // 5: reset during LATCH, then during ECHO
        do_reset();
        push_raw("M");
        wait_rd(seen);
        chk("t5_rd", 32'(seen), 32'd1);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        chk_quiet("t5_latch");
        iRst = 1'b0;
        repeat (20) @(negedge iClk);
        chk("t5a_npres", pres_q.size(), 32'd0);
        chk("t5a_necho", tx_q.size(), 32'd0);
        iTx_Full = 1'b1;
        push_raw("W");
        wait_pres(1, seen);
        chk("t5_present", 32'(seen), 32'd1);
        chk("t5_in_echo", 32'(oBusy), 32'd1);
        iRst = 1'b1;
        @(negedge iClk);
        chk_quiet("t5_echo");
        iRst = 1'b0;
        iTx_Full = 1'b0;
        repeat (20) @(negedge iClk);
        chk("t5b_necho", tx_q.size(), 32'd0);
        chk("t5b_npres", pres_q.size(), 32'd1);
        chk("t5b_cnt", 32'(oCmd_Cnt), 32'd0);

        // 6: enable gating and drop mid-byte
        do_reset();
        iEnable = 1'b0;
        push("X");
        push_raw("D");
        repeat (10) @(negedge iClk);
        chk("t6_no_pop", pop_cyc.size(), 32'd0);
        iEnable = 1'b1;
        wait_rd(seen);
        iEnable = 1'b0;
        chk("t6_rd", 32'(seen), 32'd1);
        repeat (30) @(negedge iClk);
        compare_model("t6");
        chk("t6_left", rx_q.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
